// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response encodings and FSM state types
// used by the axi_mem_slave responder and its word array.
package axi_pkg;

    typedef logic [1:0] axi_burst_t;

    localparam axi_burst_t BURST_FIXED = 2'b00;
    localparam axi_burst_t BURST_INCR  = 2'b01;
    localparam axi_burst_t BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    // FIXED bursts keep hitting the same word; every other
    // encoding (INCR, WRAP, reserved) steps by one word.
    function automatic logic burst_holds(input axi_burst_t b);
        return b == BURST_FIXED;
    endfunction

endpackage

// File: rtl/axi_mem_slave_ram.sv
// axi_mem_slave_ram: DEPTH x DATA_W word array, async read port,
// sync byte-enabled write port. Ports: clk, i_raddr/o_rdata, i_we/i_waddr/i_wdata/i_wstrb.
module axi_mem_slave_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10,
    parameter int STRB_W = 4
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // A write in the same cycle is not yet visible here, so a
    // colliding read returns the old word.
    assign o_rdata = r_mem[i_raddr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder that loops DMA bursts into an internal array.
// Ports: clk, rst (sync, active-high); s_axi_ar*/r* read; s_axi_aw*/w*/b* write.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [3:0]                s_axi_arcache,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [3:0]                s_axi_awcache,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int OFF_W = $clog2(AXI_STRB_WIDTH);

    // Sizes, attributes and the dropped address bits have no effect.
    logic w_unused;
    assign w_unused = ^{s_axi_arsize, s_axi_arlock, s_axi_arcache,
                        s_axi_arprot, s_axi_awsize, s_axi_awlock,
                        s_axi_awcache, s_axi_awprot,
                        s_axi_araddr, s_axi_awaddr};

    // ---------------- read channel ----------------
    rd_state_e r_rstate;
    rd_state_e w_rstate_nxt;

    logic [AXI_ID_WIDTH-1:0] r_rid;
    logic [IDX_W-1:0]        r_ridx;
    logic [7:0]              r_rlen;
    logic [7:0]              r_rcnt;
    axi_burst_t              r_rburst;

    logic             w_ar_hs;
    logic             w_r_hs;
    logic             w_rlast;
    logic [IDX_W-1:0] w_ridx_nxt;

    assign w_ar_hs    = s_axi_arvalid && s_axi_arready;
    assign w_r_hs     = s_axi_rvalid && s_axi_rready;
    assign w_rlast    = (r_rcnt == r_rlen);
    assign w_ridx_nxt = burst_holds(r_rburst) ? r_ridx
                                              : r_ridx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA: if (w_r_hs && w_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is high, even before the
    // reset edge has cleared the state register.
    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rlast   = 1'b0;
        if (!rst) begin
            unique case (r_rstate)
                R_IDLE: s_axi_arready = 1'b1;
                R_DATA: begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rlast  = w_rlast;
                end
                default: s_axi_arready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rid    <= '0;
            r_ridx   <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rburst <= BURST_FIXED;
        end else if (w_ar_hs) begin
            r_rid    <= s_axi_arid;
            r_ridx   <= s_axi_araddr[IDX_W+OFF_W-1:OFF_W];
            r_rlen   <= s_axi_arlen;
            r_rcnt   <= '0;
            r_rburst <= s_axi_arburst;
        end else if (w_r_hs) begin
            r_ridx <= w_ridx_nxt;
            r_rcnt <= r_rcnt + 8'd1;
        end
    end

    assign s_axi_rid   = rst ? '0 : r_rid;
    assign s_axi_rresp = RESP_OKAY;

    // ---------------- write channel ----------------
    wr_state_e r_wstate;
    wr_state_e w_wstate_nxt;

    logic [AXI_ID_WIDTH-1:0] r_wid;
    logic [IDX_W-1:0]        r_widx;
    logic [7:0]              r_wlen;
    logic [7:0]              r_wcnt;
    axi_burst_t              r_wburst;
    logic                    r_werr;

    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_wfinal;
    logic             w_wlast_bad;
    logic [IDX_W-1:0] w_widx_nxt;

    assign w_aw_hs     = s_axi_awvalid && s_axi_awready;
    assign w_w_hs      = s_axi_wvalid && s_axi_wready;
    assign w_b_hs      = s_axi_bvalid && s_axi_bready;
    assign w_wfinal    = (r_wcnt == r_wlen);
    assign w_wlast_bad = s_axi_wlast ^ w_wfinal;
    assign w_widx_nxt  = burst_holds(r_wburst) ? r_widx
                                               : r_widx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // Burst length comes from awlen only; wlast never ends it early.
    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE: if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA: if (w_w_hs && w_wfinal) w_wstate_nxt = W_RESP;
            W_RESP: if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        if (!rst) begin
            unique case (r_wstate)
                W_IDLE: s_axi_awready = 1'b1;
                W_DATA: s_axi_wready  = 1'b1;
                W_RESP: s_axi_bvalid  = 1'b1;
                default: s_axi_awready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wid    <= '0;
            r_widx   <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wburst <= BURST_FIXED;
            r_werr   <= 1'b0;
        end else if (w_aw_hs) begin
            r_wid    <= s_axi_awid;
            r_widx   <= s_axi_awaddr[IDX_W+OFF_W-1:OFF_W];
            r_wlen   <= s_axi_awlen;
            r_wcnt   <= '0;
            r_wburst <= s_axi_awburst;
            r_werr   <= 1'b0;
        end else if (w_w_hs) begin
            r_widx <= w_widx_nxt;
            r_wcnt <= r_wcnt + 8'd1;
            if (w_wlast_bad) begin
                r_werr <= 1'b1;
            end
        end
    end

    assign s_axi_bid   = rst ? '0 : r_wid;
    assign s_axi_bresp = (!rst && r_werr) ? RESP_SLVERR : RESP_OKAY;

    // ---------------- storage ----------------
    axi_mem_slave_ram #(
        .DATA_W (AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W),
        .STRB_W (AXI_STRB_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_raddr (r_ridx),
        .o_rdata (s_axi_rdata),
        .i_we    (w_w_hs),
        .i_waddr (r_widx),
        .i_wdata (s_axi_wdata),
        .i_wstrb (s_axi_wstrb)
    );

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized AXI master against a byte-array
// reference model of axi_mem_slave.
module tb_axi_mem_slave;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int IW    = 8;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = 3'd2;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [IW-1:0] awid = '0;
    logic [AW-1:0] awaddr = '0;
    logic [7:0]    awlen = '0;
    logic [2:0]    awsize = 3'd2;
    logic [1:0]    awburst = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          wlast = 1'b0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;

    axi_mem_slave #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .AXI_STRB_WIDTH (SW),
        .MEM_DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_arid    (arid),
        .s_axi_araddr  (araddr),
        .s_axi_arlen   (arlen),
        .s_axi_arsize  (arsize),
        .s_axi_arburst (arburst),
        .s_axi_arlock  (1'b0),
        .s_axi_arcache (4'd0),
        .s_axi_arprot  (3'd0),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rid     (rid),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rlast   (rlast),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_awid    (awid),
        .s_axi_awaddr  (awaddr),
        .s_axi_awlen   (awlen),
        .s_axi_awsize  (awsize),
        .s_axi_awburst (awburst),
        .s_axi_awlock  (1'b0),
        .s_axi_awcache (4'd0),
        .s_axi_awprot  (3'd0),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wlast   (wlast),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bid     (bid),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    model [DEPTH*SW];
    logic [DW-1:0] wd  [256];
    logic [SW-1:0] ws  [256];
    logic [DW-1:0] got [256];

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a / SW) % DEPTH);
    endfunction

    function automatic int nidx(input int i, input logic [1:0] b);
        return (b == 2'b00) ? i : (i + 1) % DEPTH;
    endfunction

    function automatic logic [DW-1:0] mword(input int i);
        logic [DW-1:0] w;
        for (int b = 0; b < SW; b++) w[8*b +: 8] = model[i*SW + b];
        return w;
    endfunction

    task automatic write_burst(input logic [IW-1:0] id,
                               input logic [AW-1:0] addr,
                               input int len, input logic [1:0] burst,
                               input int lastb, input bit gaps);
        int  t;
        int  i;
        int  k;
        bit  err;
        logic [1:0] exp_resp;
        err = 1'b0;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = 8'(len);
        awburst = burst; awvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!awready && t < 50) begin
            @(negedge clk); t++;
        end
        if (!awready) check("aw_wait", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(negedge clk);
        check("wready_lat", wready, 1);
        @(posedge clk); #1;
        i = widx(addr);
        for (int b = 0; b <= len; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk); #1;
            end
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b];
            wlast = (b == lastb);
            t = 0;
            @(negedge clk);
            while (!wready && t < 50) begin
                @(negedge clk); t++;
            end
            if (!wready) check("w_wait", wready, 1);
            @(posedge clk);
            for (int l = 0; l < SW; l++)
                if (ws[b][l]) model[i*SW + l] = wd[b][8*l +: 8];
            i = nidx(i, burst);
            if ((b == lastb) != (b == len)) err = 1'b1;
            #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        exp_resp = err ? 2'b10 : 2'b00;
        @(negedge clk);
        check("bvalid_lat", bvalid, 1);
        k = $urandom_range(0, 2);
        repeat (k) begin
            check("b_hold_id", bid, id);
            check("b_hold_resp", bresp, exp_resp);
            @(negedge clk);
        end
        check("bvalid", bvalid, 1);
        check("bid", bid, id);
        check("bresp", bresp, exp_resp);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("awready_after_b", awready, 1);
    endtask

    task automatic read_burst(input logic [IW-1:0] id,
                              input logic [AW-1:0] addr,
                              input int len, input logic [1:0] burst,
                              input int mode);
        int t;
        int i;
        int s;
        logic [DW-1:0] held;
        logic          held_last;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = 8'(len);
        arburst = burst; arvalid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!arready && t < 50) begin
            @(negedge clk); t++;
        end
        if (!arready) check("ar_wait", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b0;
        i = widx(addr);
        @(negedge clk);
        check("rvalid_lat", rvalid, 1);
        for (int b = 0; b <= len; b++) begin
            s = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 2);
            held = rdata;
            held_last = rlast;
            repeat (s) begin
                @(posedge clk); @(negedge clk);
                check("r_hold_data", rdata, held);
                check("r_hold_last", rlast, held_last);
                check("r_hold_id", rid, id);
            end
            check("rvalid", rvalid, 1);
            check("rdata", rdata, mword(i));
            check("rlast", rlast, (b == len));
            check("rid", rid, id);
            check("rresp", rresp, 2'b00);
            got[b] = rdata;
            rready = 1'b1;
            @(posedge clk); #1;
            rready = 1'b0;
            i = nidx(i, burst);
            @(negedge clk);
        end
        check("arready_ret", arready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_incr [4];
        int len;
        logic [AW-1:0] a;
        logic [1:0] bt;
        exp_incr[0] = 32'h11; exp_incr[1] = 32'h22;
        exp_incr[2] = 32'h33; exp_incr[3] = 32'h44;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rid", rid, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_arready", arready, 1);
        check("post_rst_awready", awready, 1);

        // W before AW must be refused
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = '1;
        @(negedge clk);
        check("w_before_aw", wready, 0);
        @(posedge clk); #1;
        wvalid = 1'b0;

        // fill the whole array so every later read is defined
        for (int q = 0; q < 4; q++) begin
            for (int b = 0; b < 256; b++) begin
                wd[b] = $urandom; ws[b] = '1;
            end
            write_burst(8'(q), AW'(q * 256 * SW), 255, 2'b01, 255, 1'b0);
        end

        // INCR write 0x11..0x44 then stalled read back
        for (int b = 0; b < 4; b++) begin
            wd[b] = exp_incr[b]; ws[b] = 4'hF;
        end
        write_burst(8'h3C, 32'h100, 3, 2'b01, 3, 1'b1);
        read_burst(8'hC3, 32'h100, 3, 2'b01, 1);
        for (int b = 0; b < 4; b++) check("incr_word", got[b], exp_incr[b]);

        // strobes on a FIXED burst
        wd[0] = 32'hAAAA_AAAA; ws[0] = 4'hF;
        write_burst(8'h01, 32'h200, 0, 2'b01, 0, 1'b0);
        wd[0] = 32'h5555_5555; ws[0] = 4'h1;
        wd[1] = 32'h5555_5555; ws[1] = 4'h8;
        write_burst(8'h02, 32'h200, 1, 2'b00, 1, 1'b0);
        read_burst(8'h03, 32'h200, 0, 2'b01, 0);
        check("strobe_fixed", got[0], 32'h55AA_AA55);

        // early wlast: four beats still taken, SLVERR
        for (int b = 0; b < 4; b++) begin
            wd[b] = $urandom; ws[b] = 4'hF;
        end
        write_burst(8'h44, 32'h400, 3, 2'b01, 1, 1'b0);

        // wrap at the top of the array, with a concurrent write
        for (int b = 0; b < 2; b++) begin
            wd[b] = $urandom; ws[b] = 4'hF;
        end
        write_burst(8'h10, 32'hFFC, 1, 2'b01, 1, 1'b0);
        for (int b = 0; b < 8; b++) begin
            wd[b] = $urandom; ws[b] = 4'($urandom);
        end
        fork
            read_burst(8'h77, 32'hFFC, 1, 2'b01, 2);
            write_burst(8'h21, 32'h300, 7, 2'b10, 7, 1'b1);
        join
        check("wrap_word0", got[1], mword(0));

        // reset during beat 2 of a 4-beat read
        @(posedge clk); #1;
        arid = 8'h5A; araddr = 32'h100; arlen = 8'd3;
        arburst = 2'b01; arvalid = 1'b1;
        @(negedge clk);
        check("mid_ar_ready", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1; rready = 1'b0;
        @(negedge clk);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rlast", rlast, 0);
        check("mid_rst_arready", arready, 0);
        check("mid_rst_rid", rid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_post_arready", arready, 1);
        check("mid_post_rvalid", rvalid, 0);
        check("mid_post_awready", awready, 1);
        read_burst(8'h5B, 32'h100, 3, 2'b01, 2);
        for (int b = 0; b < 4; b++) check("reread_word", got[b], exp_incr[b]);

        // randomized write / read-back pairs
        for (int n = 0; n < 24; n++) begin
            len = $urandom_range(0, 15);
            a = $urandom;
            bt = 2'($urandom_range(0, 3));
            for (int b = 0; b <= len; b++) begin
                wd[b] = $urandom; ws[b] = 4'($urandom);
            end
            write_burst(8'($urandom), a, len, bt, len, 1'b1);
            read_burst(8'($urandom), a, len, bt, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
